// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: FSM states, forward selects, write-mode decode.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RSTF = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Same encoding the decoder uses for "this instruction does not write rd".
    localparam logic [2:0] NOREGWRITE = 3'b000;

    function automatic logic reg_writes(input logic [2:0] mode);
        return mode != NOREGWRITE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Per-operand EX forwarding select: MEM result beats WB result; x0 and unused operands never forward.
module forward_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic       use_i,
    input  logic [4:0] rd_m_i,
    input  logic [2:0] reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic [2:0] reg_write_w_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (use_i && rs_e_i != 5'd0) begin
            if (reg_writes(reg_write_m_i) && rd_m_i == rs_e_i) begin
                sel_o = FWD_MEM;
            end else if (reg_writes(reg_write_w_i) && rd_w_i == rs_e_i) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RV32I 5-stage hazard controller: stall/flush, EX forwarding, data-memory wait FSM and watchdog.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [1:0]       RegReadD,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [1:0]       RegReadE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       RegWriteE,
    input  logic [2:0]       RegWriteM,
    input  logic [2:0]       RegWriteW,
    input  logic             MemToRegE,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic             DMemReqM,
    input  logic             DMemAck,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic             MemTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WCNT_MAX = WCW'(MEM_TIMEOUT);

    hz_state_e      state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           timeout_q, timeout_d;
    logic           rstf, mem_stall, load_use, ctrl_flush;
    logic [1:0]     fwd1, fwd2;
    logic           unused_regwrite_e;

    // A load always writes rd, so the EX write mode adds nothing to load-use detection.
    assign unused_regwrite_e = ^RegWriteE;

    assign rstf       = !CPU_RST_N || state_q == RSTF;
    assign mem_stall  = !rstf && !DMemAck && (state_q == WAIT || DMemReqM);
    assign ctrl_flush = BranchE || JalrE;
    assign load_use   = MemToRegE && RdE != 5'd0 &&
                        ((RegReadD[1] && Rs1D == RdE) || (RegReadD[0] && Rs2D == RdE));

    always_comb begin
        state_d = state_q;
        StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0; StallW = 1'b0;
        FlushF = 1'b0; FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
        case (state_q)
            RSTF:    state_d = IDLE;
            IDLE:    if (DMemReqM && !DMemAck) state_d = WAIT;
            WAIT:    if (DMemAck) state_d = IDLE;
            default: state_d = RSTF;
        endcase
        if (rstf) begin
            FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
        end else if (mem_stall) begin
            // A taken branch is held in EX and resolved once the memory releases.
            StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
            FlushW = 1'b1;
        end else if (ctrl_flush) begin
            FlushD = 1'b1; FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        end else if (JalD) begin
            FlushD = 1'b1;
        end
    end

    always_comb begin
        wcnt_d = '0;
        if (state_q == WAIT) begin
            wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCW'(1);
        end
        timeout_d = timeout_q || (wcnt_d == WCNT_MAX);
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state_q   <= RSTF;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign MemTimeout = timeout_q;

    forward_sel u_fwd1 (
        .rs_e_i        (Rs1E),
        .use_i         (RegReadE[1]),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd1)
    );

    forward_sel u_fwd2 (
        .rs_e_i        (Rs2E),
        .use_i         (RegReadE[0]),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd2)
    );

    assign Forward1E = rstf ? FWD_RF : fwd1;
    assign Forward2E = rstf ? FWD_RF : fwd2;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != RSTF) begin
            if (StallF) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (FlushD || FlushE) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. Consumes register indices and control fields from the ID/EX/MEM/WB stages and the data-memory handshake. Produces per-stage stall/flush controls and EX-stage operand-forwarding selects. Contains the data-memory wait state machine, the post-reset flush sequence and a memory-timeout watchdog.

## Interface
- MEM_TIMEOUT, 64: maximum wait cycles for a data-memory access before MemTimeout is raised (must be ≥ 2)
- CNT_W, 32: width of the performance counters (used only with the counter feature)

Ports. One clock; reset is synchronous and active-low.
- CPU_CLK  in  1  pipeline clock
- CPU_RST_N  in  1  synchronous active-low reset
- Rs1D, Rs2D  in  5 each  ID source registers
- RegReadD  in  2  ID operand-use mask: [1] Rs1, [0] Rs2
- Rs1E, Rs2E  in  5 each  EX source registers
- RdE, RdM, RdW  in  5 each  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  3 each  write mode; any nonzero value means a register write
- MemToRegE  in  1  EX instruction is a load
- BranchE  in  1  EX branch resolved taken
- JalrE  in  1  jalr in EX
- JalD  in  1  jal in ID
- DMemReqM  in  1  MEM instruction accesses data memory
- DMemAck  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM, StallW  out  1 each  hold the stage register
- FlushF, FlushD, FlushE, FlushM, FlushW  out  1 each  load a bubble into the stage register
- Forward1E, Forward2E  out  2 each  2'b10 from MEM, 2'b01 from WB, 2'b00 from the register file
- MemTimeout  out  1  sticky watchdog error
- StallCnt, FlushCnt  out  CNT_W each  only when the counter feature is compiled in

## Operation
- FSM states:
  - RSTF: all Flush* = 1 and all Stall* = 0. Entered while CPU_RST_N = 0; held for exactly one cycle after release; then IDLE.
  - IDLE: if DMemReqM & !DMemAck, go to WAIT. A stall is asserted in the same cycle (combinational on inputs).
  - WAIT: stall stays asserted until DMemAck = 1. The ack cycle releases the stall combinationally, and the next state is IDLE.
- Memory stall: StallF, StallD, StallE, StallM = 1 and FlushW = 1. It overrides every other hazard; no flush is issued to F–M while it is active. A taken branch stays in EX and is acted on when the stall releases.
- Load-use hazard: MemToRegE & RdE≠0 & ((RegReadD[1] & Rs1D==RdE) | (RegReadD[0] & Rs2D==RdE)). Response: StallF = StallD = 1, FlushE = 1.
- Control hazards:
  - BranchE | JalrE: FlushD = FlushE = 1.
  - JalD alone: FlushD = 1.
- Priority: memory stall > BranchE/JalrE > load-use > JalD. A branch flush cancels a simultaneous load-use stall.
- Forwarding (combinational, per operand):
  - From MEM when RegWriteM≠0 & RdM≠0 & RdM==RsxE & RegReadE bit set.
  - Otherwise from WB under the same conditions with the W-stage fields.
  - Otherwise 00.
  - MEM wins over WB. x0 never forwards.
- Watchdog:
  - The wait counter clears in IDLE and increments each WAIT cycle, saturating at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, MemTimeout is set. It is cleared only by reset.
  - The FSM keeps waiting; there is no forced abort.
- Reset mid-WAIT: the next edge with CPU_RST_N = 0 goes to RSTF. The counter and MemTimeout are cleared.

## Timing
- Reset values: all Flush* = 1, all Stall* = 0, Forward*E = 00, MemTimeout = 0, counters = 0.
- Stall and flush outputs are combinational from inputs and state, valid in the same cycle. Registered state affects them from the next edge.
- MemTimeout rises on the edge that takes the counter to MEM_TIMEOUT, i.e. at WAIT cycle MEM_TIMEOUT.
- A zero-wait memory (Req and Ack in the same cycle) produces no stall cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCnt increments on every cycle with StallF = 1; FlushCnt increments on every cycle with FlushD | FlushE = 1, excluding RSTF. Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: the ports and counters are absent.

## Structure
- Shared package holds:
  - FSM state encoding (RSTF, IDLE, WAIT)
  - forward-select constants (FWD_RF, FWD_WB, FWD_MEM)
  - the NOREGWRITE value, so "register write" is decoded consistently with the decoder
- One sub-module: forward_sel, the per-operand comparator, instantiated twice (operand 1 and operand 2).

## Test plan
- Reset release: RSTF lasts 1 cycle with all Flush* = 1, then IDLE with all outputs 0.
- add x5 in MEM and add x5 in WB, Rs1E = 5: Forward1E = 10. Repeat with RdM = 0: 01. RdW = 0 as well: 00.
- lw x3 in EX, ID reads x3 via Rs2D with RegReadD = 01: StallF = StallD = FlushE = 1 for one cycle. Same cycle with BranchE = 1: only FlushD = FlushE.
- DMemReqM = 1 with Ack after 3 cycles: stall for 3 cycles, FlushW = 1 each of those cycles, released on the ack cycle. Ack in the same cycle as the request: 0 stall cycles.
- MEM_TIMEOUT = 4, Ack withheld for 10 cycles: MemTimeout rises at wait cycle 4 and stays set through a later ack; cleared by CPU_RST_N = 0.
- HAZARD_PERF_CNT_EN defined: the above sequence gives StallCnt = the summed stall cycles and FlushCnt = the flush cycles.
